// File: rtl/seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_multiplier
// Description : Radix-2 shift-add signed multiplier with start/busy/done
//               handshake. Optional macro SATURATE_EN clamps prod on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     prod,
    output logic [2*WIDTH-1:0]   prod_full,
    output logic                 ovf
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0]   c_POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WIDTH-1:0]       r_mag_a;
    logic [WIDTH-1:0]       r_mag_b;
    logic                   r_sign;
    logic [2*WIDTH-1:0]     r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_done;
    logic [WIDTH-1:0]       r_prod;
    logic [2*WIDTH-1:0]     r_prod_full;
    logic                   r_ovf;

    logic                   w_start_accept;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_full;
    logic [WIDTH:0]         w_upper;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_prod;

    assign w_start_accept = (r_state == S_IDLE) && start;

    // The most negative operand maps to 2^(WIDTH-1), which fits unsigned.
    assign w_mag_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_mag_b  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_addend = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

    assign w_full  = r_sign ? (~r_acc + 1'b1) : r_acc;
    // Product fits WIDTH bits only if the top WIDTH+1 bits are a pure sign run.
    assign w_upper = w_full[2*WIDTH-1:WIDTH-1];
    assign w_ovf   = (w_upper != '0) && (w_upper != '1);

`ifdef SATURATE_EN
    assign w_prod = w_ovf ? (w_full[2*WIDTH-1] ? c_NEG_MIN : c_POS_MAX)
                          : w_full[WIDTH-1:0];
`else
    assign w_prod = w_full[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_MUL;
            S_MUL:   if (r_cnt == c_CNT_LAST) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_sign      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_prod      <= '0;
            r_prod_full <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_accept) begin
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_MUL) begin
                if (r_mag_b[r_cnt]) begin
                    r_acc <= r_acc + w_addend;
                end
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_FIX) begin
                r_prod_full <= w_full;
                r_prod      <= w_prod;
                r_ovf       <= w_ovf;
                r_done      <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign prod      = r_prod;
    assign prod_full = r_prod_full;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
